// File: rtl/opb_regbank_ppc2simulink_pkg.sv
`default_nettype none
// ============================================================================
// Module   : opb_regbank_ppc2simulink_pkg
// Brief    : Shared FSM encodings, commit-register location and byte-lane merge.
// Revision : 1.0 - initial release
// ============================================================================
package opb_regbank_ppc2simulink_pkg;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_ack  = 2'd1;
  localparam logic [1:0] c_st_hold = 2'd2;

  localparam logic [5:0] c_commit_widx = 6'd63;
  // Commit bit in OPB big-endian numbering (DBus[31] is the LSB)
  localparam int c_commit_bit  = 31;
  localparam int c_commit_ubit = 31 - c_commit_bit;
  localparam int c_commit_lane = c_commit_ubit / 8;

  typedef struct packed {
    logic [5:0]  widx;
    logic        rnw;
    logic [3:0]  be;
    logic [31:0] data;
    logic        err;
  } beat_t;

  // be[i] enables user byte i (bits 8i+7:8i)
  function automatic logic [31:0] be_merge(input logic [31:0] cur,
                                           input logic [31:0] wdat,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdat[8*i +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/opb_regbank_ppc2simulink_if.sv
`default_nettype none
// ============================================================================
// Module   : opb_regbank_ppc2simulink_if
// Brief    : OPB slave-side bus bundle (big-endian bit numbering).
// Revision : 1.0 - initial release
// ============================================================================
interface opb_regbank_ppc2simulink_if #(
  parameter int C_OPB_AWIDTH = 32,
  parameter int C_OPB_DWIDTH = 32
);
  logic [0:C_OPB_AWIDTH-1]   OPB_ABus;
  logic [0:C_OPB_DWIDTH/8-1] OPB_BE;
  logic [0:C_OPB_DWIDTH-1]   OPB_DBus;
  logic                      OPB_RNW;
  logic                      OPB_select;
  logic                      OPB_seqAddr;
  logic [0:C_OPB_DWIDTH-1]   Sl_DBus;
  logic                      Sl_errAck;
  logic                      Sl_retry;
  logic                      Sl_toutSup;
  logic                      Sl_xferAck;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
  );
endinterface
`default_nettype wire

// File: rtl/opb_regbank_ppc2simulink_fsm.sv
`default_nettype none
// ============================================================================
// Module   : opb_regbank_ppc2simulink_fsm
// Brief    : Address decode, IDLE/ACK/HOLD handshake FSM and latched bus beat.
// Revision : 1.0 - initial release
// ============================================================================
module opb_regbank_ppc2simulink_fsm
  import opb_regbank_ppc2simulink_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0108D500,
  parameter logic [31:0] C_HIGHADDR   = 32'h0108D5FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_N_REGS     = 8
) (
  input  wire logic                      clk,
  input  wire logic                      rst_n,
  input  wire logic                      i_select,
  input  wire logic                      i_rnw,
  input  wire logic [0:C_OPB_AWIDTH-1]   i_abus,
  input  wire logic [0:C_OPB_DWIDTH/8-1] i_be,
  input  wire logic [0:C_OPB_DWIDTH-1]   i_dbus,
  output logic                           o_xfer_ack,
  output logic                           o_err_ack,
  output logic                           o_wr_en,
  output logic                           o_rd_en,
  output logic [5:0]                     o_widx,
  output logic [3:0]                     o_be,
  output logic [31:0]                    o_data
);

  logic [1:0] r_state;
  logic [1:0] w_next;
  beat_t      r_beat;
  logic       w_hit;
  logic [5:0] w_widx;
  logic       w_err;

  assign w_hit  = i_select && (i_abus >= C_BASEADDR) && (i_abus <= C_HIGHADDR);
  assign w_widx = i_abus[C_OPB_AWIDTH-8 : C_OPB_AWIDTH-3];
  // Word 63 is the commit register and never an error, even with 63 user regs
  assign w_err  = (w_widx >= 6'(C_N_REGS)) && (w_widx != c_commit_widx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_st_idle;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle: if (w_hit) w_next = c_st_ack;
      c_st_ack:  w_next = c_st_hold;
      c_st_hold: if (!i_select) w_next = c_st_idle;
      default:   w_next = c_st_idle;
    endcase
  end

  always_comb begin
    o_xfer_ack = (r_state == c_st_ack);
    o_err_ack  = o_xfer_ack && r_beat.err;
    o_wr_en    = o_xfer_ack && !r_beat.rnw && !r_beat.err;
    o_rd_en    = o_xfer_ack &&  r_beat.rnw && !r_beat.err;
    o_widx     = r_beat.widx;
    o_be       = r_beat.be;
    o_data     = r_beat.data;
  end

  // Bit-reversing assignment: OPB bit 0 lands in user bit 31
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat <= '0;
    end else if ((r_state == c_st_idle) && w_hit) begin
      r_beat.widx <= w_widx;
      r_beat.rnw  <= i_rnw;
      r_beat.be   <= i_be;
      r_beat.data <= i_dbus;
      r_beat.err  <= w_err;
    end
  end

endmodule
`default_nettype wire

// File: rtl/opb_regbank_ppc2simulink.sv
`default_nettype none
// ============================================================================
// Module   : opb_regbank_ppc2simulink
// Brief    : OPB register bank with byte-enable writes, readback, update strobes
//            and optional shadow/commit for atomic multi-register updates.
// Revision : 1.0 - initial release
// ============================================================================
module opb_regbank_ppc2simulink
  import opb_regbank_ppc2simulink_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0108D500,
  parameter logic [31:0] C_HIGHADDR   = 32'h0108D5FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_N_REGS     = 8,
  parameter int          C_SHADOW     = 1,
  parameter logic [31:0] C_RESET_VAL  = 32'h00000000
) (
  input  wire logic                  OPB_Clk,
  input  wire logic                  OPB_Rst_n,
  opb_regbank_ppc2simulink_if.slave  opb,
  output logic [32*C_N_REGS-1:0]     user_data_out,
  output logic [C_N_REGS-1:0]        user_upd_stb
);

  logic        w_xfer_ack;
  logic        w_err_ack;
  logic        w_wr_en;
  logic        w_rd_en;
  logic [5:0]  w_widx;
  logic [3:0]  w_be;
  logic [31:0] w_data;
  logic [31:0] w_rdata;
  logic        w_unused_seq;

  logic [31:0] r_out [C_N_REGS];
  logic [31:0] w_src [C_N_REGS];
  logic        r_stb [C_N_REGS];

  opb_regbank_ppc2simulink_fsm #(
    .C_BASEADDR   (C_BASEADDR),
    .C_HIGHADDR   (C_HIGHADDR),
    .C_OPB_AWIDTH (C_OPB_AWIDTH),
    .C_OPB_DWIDTH (C_OPB_DWIDTH),
    .C_N_REGS     (C_N_REGS)
  ) u_fsm (
    .clk        (OPB_Clk),
    .rst_n      (OPB_Rst_n),
    .i_select   (opb.OPB_select),
    .i_rnw      (opb.OPB_RNW),
    .i_abus     (opb.OPB_ABus),
    .i_be       (opb.OPB_BE),
    .i_dbus     (opb.OPB_DBus),
    .o_xfer_ack (w_xfer_ack),
    .o_err_ack  (w_err_ack),
    .o_wr_en    (w_wr_en),
    .o_rd_en    (w_rd_en),
    .o_widx     (w_widx),
    .o_be       (w_be),
    .o_data     (w_data)
  );

  // Every beat is treated as a single transfer
  assign w_unused_seq = opb.OPB_seqAddr;

  generate
    if (C_SHADOW != 0) begin : g_shadow
      logic [31:0] r_shadow [C_N_REGS];
      logic        w_commit;

      // Commit needs the byte lane holding the commit bit enabled
      assign w_commit = w_wr_en && (w_widx == c_commit_widx) &&
                        w_be[c_commit_lane] && w_data[c_commit_ubit];

      for (genvar k = 0; k < C_N_REGS; k++) begin : g_reg
        always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
          if (!OPB_Rst_n) begin
            r_shadow[k] <= C_RESET_VAL;
            r_out[k]    <= C_RESET_VAL;
            r_stb[k]    <= 1'b0;
          end else begin
            if (w_wr_en && (w_widx == 6'(k)))
              r_shadow[k] <= be_merge(r_shadow[k], w_data, w_be);
            if (w_commit)
              r_out[k] <= r_shadow[k];
            r_stb[k] <= w_commit;
          end
        end
        assign w_src[k] = r_shadow[k];
      end
    end else begin : g_direct
      for (genvar k = 0; k < C_N_REGS; k++) begin : g_reg
        always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
          if (!OPB_Rst_n) begin
            r_out[k] <= C_RESET_VAL;
            r_stb[k] <= 1'b0;
          end else begin
            if (w_wr_en && (w_widx == 6'(k)))
              r_out[k] <= be_merge(r_out[k], w_data, w_be);
            r_stb[k] <= w_wr_en && (w_widx == 6'(k)) && (|w_be);
          end
        end
        assign w_src[k] = r_out[k];
      end
    end
  endgenerate

  generate
    for (genvar k = 0; k < C_N_REGS; k++) begin : g_out
      assign user_data_out[32*k +: 32] = r_out[k];
      assign user_upd_stb[k]           = r_stb[k];
    end
  endgenerate

  // Commit and out-of-range words never match a register, so they read as 0
  always_comb begin
    w_rdata = '0;
    for (int k = 0; k < C_N_REGS; k++) begin
      if (w_rd_en && (w_widx == 6'(k))) w_rdata = w_src[k];
    end
  end

  assign opb.Sl_DBus    = w_rdata;
  assign opb.Sl_xferAck = w_xfer_ack;
  assign opb.Sl_errAck  = w_err_ack;
  assign opb.Sl_retry   = 1'b0;
  assign opb.Sl_toutSup = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_opb_regbank_ppc2simulink.sv
`default_nettype none
// ============================================================================
// Module   : tb_opb_regbank_ppc2simulink
// Brief    : Directed + random bench for direct and shadow register banks.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_opb_regbank_ppc2simulink;

  localparam logic [31:0] c_base  = 32'h0108D500;
  localparam logic [31:0] c_high  = 32'h0108D5FF;
  localparam int          c_nregs = 8;

  logic clk;
  logic rst_n;
  logic [32*c_nregs-1:0] user_d, user_s;
  logic [c_nregs-1:0]    stb_d, stb_s;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: direct outputs, shadow-mode shadows and outputs
  logic [31:0] m_dir [c_nregs];
  logic [31:0] m_shd [c_nregs];
  logic [31:0] m_out [c_nregs];

  opb_regbank_ppc2simulink_if bus_d ();
  opb_regbank_ppc2simulink_if bus_s ();

  opb_regbank_ppc2simulink #(.C_SHADOW(0), .C_N_REGS(c_nregs)) dut_dir (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .opb(bus_d.slave),
    .user_data_out(user_d), .user_upd_stb(stb_d));

  opb_regbank_ppc2simulink #(.C_SHADOW(1), .C_N_REGS(c_nregs)) dut_shd (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .opb(bus_s.slave),
    .user_data_out(user_s), .user_upd_stb(stb_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit shd, input bit sel, input logic [31:0] a, input bit rnw,
                       input logic [3:0] be, input logic [31:0] d);
    bit sq;
    sq = 1'($urandom_range(0, 1));
    if (shd) begin
      bus_s.OPB_select = sel; bus_s.OPB_ABus = a; bus_s.OPB_RNW = rnw;
      bus_s.OPB_BE = be; bus_s.OPB_DBus = d; bus_s.OPB_seqAddr = sq;
    end else begin
      bus_d.OPB_select = sel; bus_d.OPB_ABus = a; bus_d.OPB_RNW = rnw;
      bus_d.OPB_BE = be; bus_d.OPB_DBus = d; bus_d.OPB_seqAddr = sq;
    end
  endtask

  function automatic bit ack_of(input bit shd);
    return shd ? bus_s.Sl_xferAck : bus_d.Sl_xferAck;
  endfunction
  function automatic bit err_of(input bit shd);
    return shd ? bus_s.Sl_errAck : bus_d.Sl_errAck;
  endfunction
  function automatic logic [31:0] dbus_of(input bit shd);
    return shd ? bus_s.Sl_DBus : bus_d.Sl_DBus;
  endfunction

  function automatic logic [32*c_nregs-1:0] pack(input bit shd);
    logic [32*c_nregs-1:0] v;
    for (int k = 0; k < c_nregs; k++) v[32*k +: 32] = shd ? m_out[k] : m_dir[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < c_nregs; k++) begin
      m_dir[k] = '0; m_shd[k] = '0; m_out[k] = '0;
    end
  endtask

  // One complete bus beat, checked against the reference model
  task automatic do_beat(input bit shd, input logic [31:0] a, input bit rnw,
                         input logic [3:0] be, input logic [31:0] d);
    logic [31:0] exp_rd, got_rd, mask, off;
    logic [7:0]  stb_e;
    int widx, lat;
    bit hit, err_e, got_err, seen;
    hit    = (a >= c_base) && (a <= c_high);
    off    = a - c_base;
    widx   = hit ? int'(off >> 2) : 0;
    err_e  = hit && (widx >= c_nregs) && (widx != 63);
    exp_rd = '0;
    if (hit && rnw && widx < c_nregs) exp_rd = shd ? m_shd[widx] : m_dir[widx];

    @(negedge clk);
    drive(shd, 1'b1, a, rnw, be, d);
    seen = 0; lat = 0; got_rd = '0; got_err = 0;
    for (int i = 1; i <= 4 && !seen; i++) begin
      @(negedge clk);
      if (ack_of(shd)) begin
        seen = 1; lat = i; got_rd = dbus_of(shd); got_err = err_of(shd);
      end
    end
    drive(shd, 1'b0, a, rnw, be, d);

    if (!hit) begin
      check_eq("no_ack_outside", 256'(seen), 256'(0));
    end else begin
      check_eq("ack_latency", 256'(lat), 256'(1));
      check_eq("err_ack", 256'(got_err), 256'(err_e));
      check_eq("read_data", 256'(got_rd), 256'(exp_rd));
    end

    mask  = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    stb_e = '0;
    if (hit && !rnw && !err_e) begin
      if (widx < c_nregs) begin
        if (shd) m_shd[widx] = (m_shd[widx] & ~mask) | (d & mask);
        else begin
          m_dir[widx] = (m_dir[widx] & ~mask) | (d & mask);
          if (be != 4'b0) stb_e[widx] = 1'b1;
        end
      end else if (shd && be[0] && d[0]) begin
        for (int k = 0; k < c_nregs; k++) m_out[k] = m_shd[k];
        stb_e = 8'hFF;
      end
    end

    @(negedge clk);
    check_eq("upd_stb", 256'(shd ? stb_s : stb_d), 256'(stb_e));
    check_eq("user_out", 256'(shd ? user_s : user_d), 256'(pack(shd)));
    check_eq("idle_bus", {223'(0), ack_of(shd), dbus_of(shd)}, 256'(0));
    @(negedge clk);
    check_eq("stb_one_cycle", 256'(shd ? stb_s : stb_d), 256'(0));
  endtask

  initial begin
    int acks, bad_dbus;
    bit shd, rnw;
    int sel;
    logic [31:0] a, d;
    logic [3:0]  be;

    rst_n = 1'b0;
    drive(0, 0, '0, 0, '0, '0);
    drive(1, 0, '0, 0, '0, '0);
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_user_d", 256'(user_d), 256'(0));
    check_eq("rst_user_s", 256'(user_s), 256'(0));
    check_eq("rst_stb", 256'({stb_d, stb_s}), 256'(0));
    check_eq("rst_ack", 256'({bus_d.Sl_xferAck, bus_s.Sl_xferAck, bus_d.Sl_errAck}), 256'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Direct mode: full write, byte-enable merge, readback
    do_beat(0, 32'h0108D504, 0, 4'b1111, 32'hDEADBEEF);
    do_beat(0, 32'h0108D508, 0, 4'b1111, 32'h11223344);
    do_beat(0, 32'h0108D508, 0, 4'b0101, 32'hAABBCCDD);
    check_eq("be_merge_model", 256'(m_dir[2]), 256'(32'h11BB33DD));
    do_beat(0, 32'h0108D508, 1, 4'b1111, 32'h0);
    do_beat(0, 32'h0108D504, 0, 4'b0000, 32'h12345678);
    do_beat(0, 32'h0108D5FC, 0, 4'b1111, 32'h00000001);

    // Shadow mode: staged writes, rejected and accepted commits
    do_beat(1, 32'h0108D500, 0, 4'b1111, 32'h00000005);
    do_beat(1, 32'h0108D51C, 0, 4'b1111, 32'h00000009);
    do_beat(1, 32'h0108D51C, 1, 4'b1111, 32'h0);
    do_beat(1, 32'h0108D5FC, 0, 4'b1111, 32'h00000000);
    do_beat(1, 32'h0108D5FC, 0, 4'b1111, 32'h00000001);
    do_beat(1, 32'h0108D5FC, 1, 4'b1111, 32'h0);

    // Out of range and outside the window
    do_beat(0, 32'h0108D540, 1, 4'b1111, 32'h0);
    do_beat(0, 32'h0108D540, 0, 4'b1111, 32'hFFFFFFFF);
    do_beat(1, 32'h0108D5F8, 0, 4'b1111, 32'hFFFFFFFF);
    do_beat(0, 32'h0108D600, 0, 4'b1111, 32'hCAFEF00D);
    do_beat(1, 32'h0108D4FC, 1, 4'b1111, 32'h0);

    // Held select: only one ack, bus data zero outside it
    @(negedge clk);
    drive(0, 1, 32'h0108D504, 1, 4'b1111, 32'h0);
    acks = 0; bad_dbus = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus_d.Sl_xferAck) begin
        acks++;
        check_eq("held_rdata", 256'(bus_d.Sl_DBus), 256'(m_dir[1]));
      end else if (bus_d.Sl_DBus != 32'h0) bad_dbus++;
    end
    drive(0, 0, 32'h0108D504, 1, 4'b1111, 32'h0);
    check_eq("held_one_ack", 256'(acks), 256'(1));
    check_eq("held_dbus_zero", 256'(bad_dbus), 256'(0));
    repeat (2) @(negedge clk);

    // Reset during the ack cycle of a write: write lost, no ack seen
    drive(0, 1, 32'h0108D50C, 0, 4'b1111, 32'h12345678);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_ack", 256'(bus_d.Sl_xferAck), 256'(0));
    check_eq("rst_mid_user_d", 256'(user_d), 256'(0));
    check_eq("rst_mid_user_s", 256'(user_s), 256'(0));
    drive(0, 0, '0, 0, '0, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_write_lost", 256'(user_d), 256'(0));

    // Randomized traffic on both banks
    for (int n = 0; n < 240; n++) begin
      shd = 1'($urandom_range(0, 1));
      rnw = 1'($urandom_range(0, 1));
      be  = 4'($urandom);
      d   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = $urandom_range(0, 1) ? c_base - 32'd4 : c_high + 32'd1;
      else if (sel <= 2) begin
        a = c_base + 32'hFC;
        if ($urandom_range(0, 1)) d[0] = 1'b1;
      end
      else if (sel == 3) a = c_base + 32'(4 * $urandom_range(0, 62));
      else               a = c_base + 32'(4 * $urandom_range(0, c_nregs - 1));
      do_beat(shd, a, rnw, be, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
